// File: rtl/ir_multi_score_counter.sv
// rtl/ir_multi_score_counter.sv - multi-channel debounced IR hit counter with saturating scores and 7-seg display
module ir_multi_score_counter #(
    parameter int NUM_CH       = 2,
    parameter int DEBOUNCE_CYC = 2_000_000,
    parameter int HOLDOFF_CYC  = 50_000_000,
    parameter int MAX_SCORE    = 50,
    parameter int DIGITS       = 2,
    parameter int REFRESH_BITS = 17,
    localparam int SCORE_W     = $clog2(MAX_SCORE + 1),
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk_100MHz,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         ir_sensor,
    input  logic                      clear,
    input  logic [CH_W-1:0]           disp_ch,
    output logic [NUM_CH*SCORE_W-1:0] score_bus,
    output logic [NUM_CH-1:0]         hit_pulse,
    output logic                      winner_valid,
    output logic [CH_W-1:0]           winner_id,
    output logic [6:0]                seg,
    output logic [3:0]                an
);
    localparam int DB_W  = ($clog2(DEBOUNCE_CYC + 1) > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam int HO_W  = ($clog2(HOLDOFF_CYC + 1) > 0) ? $clog2(HOLDOFF_CYC + 1) : 1;
    localparam int BCD_W = DIGITS * 4;

    logic [NUM_CH-1:0] at_max;
    logic [BCD_W-1:0]  bcd_all [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             s1, s2, deb, deb_d;
        logic [DB_W-1:0]  db_cnt;
        logic [HO_W-1:0]  ho_cnt;
        logic [SCORE_W-1:0] score;
        logic [BCD_W-1:0] bcd, bcd_next;
        logic             hit_q, acc, carry;

        assign acc = deb & ~deb_d & (ho_cnt == '0) & ~winner_valid
                   & (score < SCORE_W'(MAX_SCORE)) & ~clear;

        // Decimal ripple increment keeps the BCD copy in lockstep with the binary score
        always_comb begin
            bcd_next = bcd;
            carry    = 1'b1;
            for (int d = 0; d < DIGITS; d++) begin
                if (carry) begin
                    if (bcd_next[d*4 +: 4] == 4'd9) begin
                        bcd_next[d*4 +: 4] = 4'd0;
                    end else begin
                        bcd_next[d*4 +: 4] = bcd_next[d*4 +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end

        // Debounce state survives clear so a beam held across a new game cannot re-score
        always_ff @(posedge clk_100MHz or negedge reset_n) begin
            if (!reset_n) begin
                s1     <= 1'b0;
                s2     <= 1'b0;
                deb    <= 1'b0;
                deb_d  <= 1'b0;
                db_cnt <= '0;
            end else begin
                s1    <= ir_sensor[i];
                s2    <= s1;
                deb_d <= deb;
                if (s2 == deb) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                    deb    <= s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end
        end

        always_ff @(posedge clk_100MHz or negedge reset_n) begin
            if (!reset_n) begin
                ho_cnt <= '0;
                score  <= '0;
                bcd    <= '0;
                hit_q  <= 1'b0;
            end else if (clear) begin
                ho_cnt <= '0;
                score  <= '0;
                bcd    <= '0;
                hit_q  <= 1'b0;
            end else begin
                hit_q <= acc;
                if (acc) begin
                    score  <= score + SCORE_W'(1);
                    bcd    <= bcd_next;
                    ho_cnt <= HO_W'(HOLDOFF_CYC);
                end else if (ho_cnt != '0) begin
                    ho_cnt <= ho_cnt - HO_W'(1);
                end
            end
        end

        assign score_bus[i*SCORE_W +: SCORE_W] = score;
        assign hit_pulse[i] = hit_q;
        assign at_max[i]    = (score == SCORE_W'(MAX_SCORE));
        assign bcd_all[i]   = bcd;
    end

    logic [CH_W-1:0] win_idx;

    always_comb begin
        win_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (at_max[i]) win_idx = CH_W'(i);
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            winner_valid <= 1'b0;
            winner_id    <= '0;
        end else if (clear) begin
            winner_valid <= 1'b0;
            winner_id    <= '0;
        end else if (!winner_valid && (|at_max)) begin
            winner_valid <= 1'b1;
            winner_id    <= win_idx;
        end
    end

    logic [REFRESH_BITS-1:0] refresh;
    logic [1:0]              dig_k;
    logic [BCD_W-1:0]        sel_bcd;
    logic                    sel_ok, lead_zero, blank;
    logic [3:0]              cur_digit;

    always_comb begin
        sel_bcd   = '0;
        sel_ok    = 1'b0;
        cur_digit = 4'd0;
        lead_zero = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (disp_ch == CH_W'(i)) begin
                sel_bcd = bcd_all[i];
                sel_ok  = 1'b1;
            end
        end
        for (int d = 0; d < DIGITS; d++) begin
            if (dig_k == 2'(d)) cur_digit = sel_bcd[d*4 +: 4];
            if ((2'(d) >= dig_k) && (sel_bcd[d*4 +: 4] != 4'd0)) lead_zero = 1'b0;
        end
        blank = !sel_ok || ((dig_k != 2'd0) && lead_zero);
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            refresh <= '0;
            dig_k   <= 2'd0;
            seg     <= 7'b1111111;
            an      <= 4'b1111;
        end else begin
            refresh <= refresh + REFRESH_BITS'(1);
            if (&refresh) begin
                dig_k <= (dig_k == 2'(DIGITS - 1)) ? 2'd0 : dig_k + 2'd1;
            end
            seg <= blank ? 7'b1111111 : seg_decode(cur_digit);
            an  <= ~(4'b0001 << dig_k);
        end
    end
endmodule

// File: tb/tb_ir_multi_score_counter.sv
// tb/tb_ir_multi_score_counter.sv - directed self-checking bench for ir_multi_score_counter
module tb_ir_multi_score_counter;
    logic       clk_100MHz = 1'b0;
    logic       reset_n;
    logic [1:0] ir_sensor;
    logic       clear;
    logic [0:0] disp_ch;
    logic [7:0] score_bus;
    logic [1:0] hit_pulse;
    logic       winner_valid;
    logic [0:0] winner_id;
    logic [6:0] seg;
    logic [3:0] an;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int hits0    = 0;
    int hits1    = 0;
    int both_cnt = 0;
    int last_hit0 = 0;

    ir_multi_score_counter #(
        .NUM_CH(2), .DEBOUNCE_CYC(8), .HOLDOFF_CYC(20),
        .MAX_SCORE(12), .DIGITS(2), .REFRESH_BITS(3)
    ) dut (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n), .ir_sensor(ir_sensor),
        .clear(clear), .disp_ch(disp_ch), .score_bus(score_bus),
        .hit_pulse(hit_pulse), .winner_valid(winner_valid), .winner_id(winner_id),
        .seg(seg), .an(an)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    always @(posedge clk_100MHz) cyc <= cyc + 1;

    always @(negedge clk_100MHz) begin
        if (hit_pulse[0]) begin
            hits0 <= hits0 + 1;
            last_hit0 <= cyc;
        end
        if (hit_pulse[1]) hits1 <= hits1 + 1;
        if (hit_pulse == 2'b11) both_cnt <= both_cnt + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    task automatic pulse(input logic [1:0] mask, input int hi, input int lo);
        ir_sensor = ir_sensor | mask;
        wait_cyc(hi);
        ir_sensor = ir_sensor & ~mask;
        wait_cyc(lo);
    endtask

    task automatic observe(output logic [6:0] ones, output logic [6:0] tens, output int bad);
        ones = 7'h55;
        tens = 7'h55;
        bad  = 0;
        repeat (40) begin
            @(negedge clk_100MHz);
            if (an == 4'b1110) ones = seg;
            else if (an == 4'b1101) tens = seg;
            else bad++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; ir_sensor = 2'b00; clear = 1'b0; disp_ch = 1'b0;
        wait_cyc(3);
        checks++; if (score_bus !== 8'h00) begin failures++; $display("FAIL reset_score got=%0h exp=0", score_bus); end
        checks++; if (hit_pulse !== 2'b00 || winner_valid !== 1'b0 || winner_id !== 1'b0) begin
            failures++; $display("FAIL reset_flags got=%b/%b/%b exp=00/0/0", hit_pulse, winner_valid, winner_id); end
        checks++; if (seg !== 7'b1111111 || an !== 4'b1111) begin
            failures++; $display("FAIL reset_disp got=%b/%b exp=1111111/1111", seg, an); end
        reset_n = 1'b1;
        wait_cyc(2);
    endtask

    task automatic test_glitch;
        int b;
        b = hits0;
        pulse(2'b01, 5, 30);
        checks++; if (hits0 !== b) begin failures++; $display("FAIL glitch_hits got=%0d exp=0", hits0 - b); end
        checks++; if (score_bus !== 8'h00) begin failures++; $display("FAIL glitch_score got=%0h exp=0", score_bus); end
    endtask

    task automatic test_single_hit;
        int b, t0;
        b = hits0;
        t0 = cyc;
        pulse(2'b01, 30, 40);
        checks++; if (hits0 - b !== 1) begin failures++; $display("FAIL single_hits got=%0d exp=1", hits0 - b); end
        checks++; if (last_hit0 - t0 !== 11) begin failures++; $display("FAIL single_latency got=%0d exp=11", last_hit0 - t0); end
        checks++; if (score_bus !== 8'h01) begin failures++; $display("FAIL single_score got=%0h exp=01", score_bus); end
        checks++; if (dut.g_ch[0].bcd !== 8'h01) begin failures++; $display("FAIL single_bcd got=%0h exp=01", dut.g_ch[0].bcd); end
    endtask

    task automatic test_holdoff;
        int b0, b1;
        b0 = hits0; b1 = hits1;
        pulse(2'b10, 12, 3);
        pulse(2'b10, 12, 40);
        checks++; if (hits1 - b1 !== 1 || score_bus !== 8'h11) begin
            failures++; $display("FAIL holdoff_close got=%0d/%0h exp=1/11", hits1 - b1, score_bus); end
        pulse(2'b10, 12, 8);
        pulse(2'b10, 12, 40);
        checks++; if (hits1 - b1 !== 2 || score_bus !== 8'h21) begin
            failures++; $display("FAIL holdoff_window got=%0d/%0h exp=2/21", hits1 - b1, score_bus); end
        checks++; if (hits0 !== b0) begin failures++; $display("FAIL holdoff_ch0 got=%0d exp=0", hits0 - b0); end
    endtask

    task automatic test_winner;
        int b0;
        for (int i = 0; i < 10; i++) pulse(2'b10, 12, 30);
        checks++; if (score_bus !== 8'hC1) begin failures++; $display("FAIL win_score got=%0h exp=c1", score_bus); end
        checks++; if (winner_valid !== 1'b1 || winner_id !== 1'b1) begin
            failures++; $display("FAIL win_flags got=%b/%b exp=1/1", winner_valid, winner_id); end
        b0 = hits0;
        pulse(2'b01, 12, 30);
        checks++; if (hits0 !== b0 || score_bus !== 8'hC1) begin
            failures++; $display("FAIL win_frozen got=%0d/%0h exp=0/c1", hits0 - b0, score_bus); end
        clear = 1'b1;
        wait_cyc(1);
        clear = 1'b0;
        checks++; if (score_bus !== 8'h00 || winner_valid !== 1'b0 || winner_id !== 1'b0) begin
            failures++; $display("FAIL win_clear got=%0h/%b/%b exp=0/0/0", score_bus, winner_valid, winner_id); end
    endtask

    task automatic test_simultaneous;
        int bb;
        for (int i = 0; i < 11; i++) pulse(2'b11, 12, 30);
        checks++; if (score_bus !== 8'hBB || winner_valid !== 1'b0) begin
            failures++; $display("FAIL sim_eleven got=%0h/%b exp=bb/0", score_bus, winner_valid); end
        bb = both_cnt;
        pulse(2'b11, 12, 30);
        checks++; if (both_cnt - bb !== 1) begin failures++; $display("FAIL sim_both got=%0d exp=1", both_cnt - bb); end
        checks++; if (score_bus !== 8'hCC) begin failures++; $display("FAIL sim_score got=%0h exp=cc", score_bus); end
        checks++; if (winner_valid !== 1'b1 || winner_id !== 1'b0) begin
            failures++; $display("FAIL sim_winner got=%b/%b exp=1/0", winner_valid, winner_id); end
        clear = 1'b1;
        wait_cyc(1);
        clear = 1'b0;
        wait_cyc(2);
    endtask

    task automatic test_display;
        logic [6:0] ones, tens;
        int bad;
        disp_ch = 1'b0;
        for (int i = 0; i < 7; i++) pulse(2'b01, 12, 30);
        observe(ones, tens, bad);
        checks++; if (ones !== 7'b1111000 || tens !== 7'b1111111) begin
            failures++; $display("FAIL disp_seven got=%b/%b exp=1111000/1111111", ones, tens); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL disp_anodes got=%0d exp=0", bad); end
        for (int i = 0; i < 3; i++) pulse(2'b01, 12, 30);
        observe(ones, tens, bad);
        checks++; if (ones !== 7'b1000000 || tens !== 7'b1111001) begin
            failures++; $display("FAIL disp_ten got=%b/%b exp=1000000/1111001", ones, tens); end
        disp_ch = 1'b1;
        observe(ones, tens, bad);
        checks++; if (ones !== 7'b1000000 || tens !== 7'b1111111) begin
            failures++; $display("FAIL disp_ch1 got=%b/%b exp=1000000/1111111", ones, tens); end
        disp_ch = 1'b0;
    endtask

    task automatic test_reset_mid;
        int b0;
        b0 = hits0;
        ir_sensor = 2'b01;
        wait_cyc(5);
        reset_n = 1'b0;
        wait_cyc(2);
        checks++; if (score_bus !== 8'h00 || hit_pulse !== 2'b00 || winner_valid !== 1'b0) begin
            failures++; $display("FAIL rmid_state got=%0h/%b/%b exp=0/00/0", score_bus, hit_pulse, winner_valid); end
        checks++; if (seg !== 7'b1111111 || an !== 4'b1111) begin
            failures++; $display("FAIL rmid_disp got=%b/%b exp=1111111/1111", seg, an); end
        ir_sensor = 2'b00;
        wait_cyc(1);
        reset_n = 1'b1;
        wait_cyc(40);
        checks++; if (hits0 !== b0 || score_bus !== 8'h00) begin
            failures++; $display("FAIL rmid_nocount got=%0d/%0h exp=0/0", hits0 - b0, score_bus); end
    endtask

    initial begin
        test_reset;
        test_glitch;
        test_single_hit;
        test_holdoff;
        test_winner;
        test_simultaneous;
        test_display;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
